// File: rtl/router_pkg.sv
// Shared constants for the router output-port FIFO: storage geometry and
// the header-byte field layout used by the read-side packet counter.
package router_pkg;

  localparam int MEM_WIDTH    = 9;
  localparam int MEM_DEPTH    = 16;
  localparam int ADD_WIDTH    = 4;
  localparam int HDR_FLAG_BIT = 8;
  localparam int CNT_WIDTH    = 7;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int DEST_MSB = 1;
  localparam int DEST_LSB = 0;

  // Bytes still to come after a header: payload length plus the parity byte.
  function automatic logic [CNT_WIDTH-1:0] pkt_remaining(input logic [MEM_WIDTH-1:0] word);
    return {1'b0, word[LEN_MSB:LEN_LSB]} + 7'd1;
  endfunction

endpackage

// File: rtl/router_fifo_ptr.sv
// FIFO pointer register: ADD_WIDTH address bits plus one wrap bit, so that
// equal addresses with differing wrap bits mean "full".
module router_fifo_ptr #(
  parameter int ADD_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 clear,
  input  logic                 inc,
  output logic [ADD_WIDTH:0]   ptr
);

  always_ff @(posedge clock) begin
    if (resetn || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/router_fifo.sv
// 16-entry router output-port FIFO with header tracking and bus release.
// Optional sticky overflow/underflow outputs under ROUTER_FIFO_ERR_FLAGS_EN.
module router_fifo
  import router_pkg::*;
(
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 write_enb,
  input  logic                 soft_reset,
  input  logic                 read_enb,
  input  logic [MEM_WIDTH-2:0] data_in,
  input  logic                 lfd_state,
  output logic                 empty,
  output logic [MEM_WIDTH-2:0] data_out,
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
  output logic                 overflow,
  output logic                 underflow,
`endif
  output logic                 full
);

  // Handshake: a write is accepted on an edge where write_enb && !full, a read
  // on an edge where read_enb && !empty; both flags are the pre-edge values and
  // a rejected request leaves the FIFO untouched. Read data appears one clock
  // after the accepting edge.
  logic [ADD_WIDTH:0]     wr_ptr;
  logic [ADD_WIDTH:0]     rd_ptr;
  logic [MEM_WIDTH-1:0]   mem [MEM_DEPTH];
  logic [MEM_WIDTH-1:0]   rd_word;
  logic [CNT_WIDTH-1:0]   count;
  logic [MEM_WIDTH-2:0]   data_q;
  logic                   bus_en;
  logic                   wr_ok;
  logic                   rd_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADD_WIDTH] != rd_ptr[ADD_WIDTH]) &&
                   (wr_ptr[ADD_WIDTH-1:0] == rd_ptr[ADD_WIDTH-1:0]);
  assign wr_ok   = write_enb && !full;
  assign rd_ok   = read_enb && !empty;
  assign rd_word = mem[rd_ptr[ADD_WIDTH-1:0]];

  router_fifo_ptr #(.ADD_WIDTH(ADD_WIDTH)) u_wr_ptr (
    .clock  (clock),
    .resetn (resetn),
    .clear  (soft_reset),
    .inc    (wr_ok),
    .ptr    (wr_ptr)
  );

  router_fifo_ptr #(.ADD_WIDTH(ADD_WIDTH)) u_rd_ptr (
    .clock  (clock),
    .resetn (resetn),
    .clear  (soft_reset),
    .inc    (rd_ok),
    .ptr    (rd_ptr)
  );

  always_ff @(posedge clock) begin
    if (resetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      count  <= '0;
      data_q <= '0;
      bus_en <= 1'b1;
    end else if (soft_reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      count  <= '0;
      data_q <= '0;
      bus_en <= 1'b0;
    end else begin
      if (wr_ok) mem[wr_ptr[ADD_WIDTH-1:0]] <= {lfd_state, data_in};
      if (rd_ok) begin
        data_q <= rd_word[MEM_WIDTH-2:0];
        bus_en <= 1'b1;
        if (rd_word[HDR_FLAG_BIT]) count <= pkt_remaining(rd_word);
        else if (count != '0)      count <= count - 7'd1;
      end else if (count == '0) begin
        // Packet finished and no read this cycle: let go of the shared bus.
        bus_en <= 1'b0;
      end
    end
  end

  assign data_out = bus_en ? data_q : 8'hzz;

`ifdef ROUTER_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clock) begin
    if (resetn || soft_reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_enb && full) overflow  <= 1'b1;
      if (read_enb && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_fifo.sv
// Bench for router_fifo: queue-based reference model, read-data scoreboard.
// Also checks overflow/underflow when ROUTER_FIFO_ERR_FLAGS_EN is defined.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       resetn;
  logic       write_enb;
  logic       soft_reset;
  logic       read_enb;
  logic [7:0] data_in;
  logic       lfd_state;
  logic       empty;
  logic       full;
  wire  [7:0] data_out;
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  int checks = 0;
  int errors = 0;

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .write_enb  (write_enb),
    .soft_reset (soft_reset),
    .read_enb   (read_enb),
    .data_in    (data_in),
    .lfd_state  (lfd_state),
    .empty      (empty),
    .data_out   (data_out),
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    .overflow   (overflow),
    .underflow  (underflow),
`endif
    .full       (full)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference model state
  logic [8:0] mq[$];
  int         m_count;
  bit         m_en;
  logic [7:0] m_data;
  bit         m_ovf, m_unf;

  // scoreboard
  logic [7:0] exp_q[$];
  bit         rd_fire = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // monitor: whenever a read was accepted at an edge, the byte must be on the bus
  initial begin
    bit fire;
    logic [7:0] exp;
    forever begin
      @(posedge clock);
      fire = rd_fire;
      #1;
      if (fire) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_data: DUT read with no expected byte at %0t", $time);
        end else begin
          exp = exp_q.pop_front();
          if (data_out !== exp) begin
            errors++;
            $display("FAIL rd_data: got %h expected %h at %0t", data_out, exp, $time);
          end
        end
      end
    end
  end

  // driver: one clock of stimulus, model update, then post-edge checks
  task automatic step(input bit we, input bit re, input logic [7:0] din,
                      input bit lfd, input bit srst, input bit rst);
    bit wr_ok, rd_ok;
    logic [8:0] w;
    @(negedge clock);
    resetn = rst; soft_reset = srst; write_enb = we; read_enb = re;
    data_in = din; lfd_state = lfd;
    rd_ok = 1'b0;
    if (rst) begin
      mq.delete(); m_count = 0; m_en = 1; m_data = 8'h00; m_ovf = 0; m_unf = 0;
    end else if (srst) begin
      mq.delete(); m_count = 0; m_en = 0; m_ovf = 0; m_unf = 0;
    end else begin
      wr_ok = we && (mq.size() < 16);
      rd_ok = re && (mq.size() > 0);
      if (we && mq.size() == 16) m_ovf = 1;
      if (re && mq.size() == 0)  m_unf = 1;
      if (rd_ok) begin
        w = mq.pop_front();
        exp_q.push_back(w[7:0]);
        m_en = 1; m_data = w[7:0];
        if (w[8]) m_count = w[7:2] + 1;
        else if (m_count != 0) m_count = m_count - 1;
      end else if (m_count == 0) begin
        m_en = 0;
      end
      if (wr_ok) mq.push_back({lfd, din});
    end
    rd_fire = rd_ok;
    @(posedge clock);
    #2;
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == 16);
    check("bus_en", dut.bus_en, m_en);
    check("count", dut.count, m_count);
    if (m_en && !rd_ok) check("data_hold", data_out, m_data);
`ifdef ROUTER_FIFO_ERR_FLAGS_EN
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
`endif
  endtask

  task automatic wr(input logic [7:0] d, input bit lfd);
    step(1, 0, d, lfd, 0, 0);
  endtask

  task automatic rd();
    step(0, 1, 8'h00, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0, 0);
  endtask

  initial begin
    resetn = 1; soft_reset = 0; write_enb = 0; read_enb = 0;
    data_in = 0; lfd_state = 0;

    // reset for two clocks, with a write attempt that must be ignored
    step(1, 0, 8'h55, 0, 0, 1);
    step(1, 0, 8'h66, 0, 0, 1);
    check("reset_data", data_out, 8'h00);

    // one packet: header length 3, three payload bytes, parity
    wr(8'b000011_01, 1);
    wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0); wr(8'h5a, 0);
    rd();
    check("hdr_count", dut.count, 4);
    repeat (4) rd();
    check("pkt_done_count", dut.count, 0);
    idle();
    check("released", dut.bus_en, 0);

    // fill to full, drop an extra write, drain
    for (int i = 0; i < 16; i++) wr(8'($urandom_range(0, 255)), 0);
    check("full_set", full, 1);
    wr(8'hAA, 0);
    repeat (16) rd();
    check("drained", empty, 1);
    rd();
    idle();

    // 8 stored, then simultaneous read/write across the pointer wrap
    for (int i = 0; i < 8; i++) wr(8'($urandom_range(0, 255)), 0);
    for (int i = 0; i < 4; i++) step(1, 1, 8'($urandom_range(0, 255)), 0, 0, 0);
    check("occupancy", mq.size(), 8);
    check("wr_ptr_wrapped", dut.wr_ptr, 1);
    repeat (8) rd();
    idle();

    // soft reset mid-packet, then a normal packet
    wr(8'b010100_10, 1);
    for (int i = 0; i < 9; i++) wr(8'($urandom_range(0, 255)), 0);
    repeat (3) rd();
    step(0, 0, 8'h00, 0, 1, 0);
    check("srst_empty", empty, 1);
    wr(8'b000001_11, 1); wr(8'h77, 0); wr(8'h88, 0);
    repeat (3) rd();
    idle();

    // read while empty
    rd();
    rd();
    check("empty_read_ptr", dut.rd_ptr, 3);

    // randomized traffic with occasional header bytes and soft resets
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0,
           $urandom_range(0, 99) == 0, 0);
    repeat (20) rd();
    idle();
    step(0, 0, 8'h00, 0, 0, 1);
    idle();
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- 16-entry synchronous FIFO that buffers one router output port's packet bytes. Sits between the router's write/sync logic (writer) and the destination port's reader.
- Each entry stores the 8-bit byte plus a 9th bit, copied from lfd_state, that marks the header byte.
- The read side uses the header's payload length to track how many bytes of the current packet remain. It releases the data_out bus (high-Z) when the packet is done.

Parameters:
- MEM_WIDTH, 9, stored word width: {header flag, data[7:0]}.
- MEM_DEPTH, 16, number of entries.
- ADD_WIDTH, 4, address width; pointers are ADD_WIDTH+1 bits (extra wrap bit).

Ports:
- clock  in  1  single clock; all logic on rising edge.
- resetn  in  1  synchronous, active-high reset (1 = reset, despite the name).
- write_enb  in  1  write request.
- soft_reset  in  1  synchronous, active-high packet-timeout flush.
- read_enb  in  1  read request.
- data_in  in  MEM_WIDTH-1 (8)  byte to write; for a header byte, [7:2] = payload length and [1:0] = destination address.
- lfd_state  in  1  high when data_in is the header byte; stored as bit 8.
- empty  out  1  FIFO holds no entries (combinational from pointers).
- data_out  out  MEM_WIDTH-1 (8)  registered read data; tri-state.
- full  out  1  FIFO holds MEM_DEPTH entries (combinational from pointers).

Behaviour:
- Priority each edge: resetn > soft_reset > normal operation.
- resetn=1:
  - wr_ptr, rd_ptr and count cleared to 0; all memory words cleared to 0.
  - data_out <= 8'h00.
  - empty=1, full=0 on the following cycle.
- soft_reset=1 (resetn=0):
  - pointers and count cleared to 0; memory cleared.
  - data_out <= 8'hZZ (high-Z).
- Write: when write_enb && !full, mem[wr_ptr[3:0]] <= {lfd_state, data_in} and wr_ptr increments. A write while full is ignored; no pointer change, no corruption.
- Read: when read_enb && !empty, data_out <= mem[rd_ptr[3:0]][7:0] and rd_ptr increments. Data is valid on data_out one clock after the sampling edge.
- Read while empty: data_out holds its value, except high-Z when count==0 (see below).
- Packet counter (7-bit count):
  - On a read of a word with bit8=1: count <= word[7:2] + 1, i.e. payload plus parity.
  - On a read of a word with bit8=0 while count!=0: count decrements by 1.
- Bus release: when count==0 and no read is performed this cycle, data_out <= 8'hZZ.
- Simultaneous read and write: both proceed when individually permitted (full/empty evaluated on pre-edge pointers). Occupancy is unchanged.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = (wr_ptr[4] != rd_ptr[4]) && (wr_ptr[3:0] == rd_ptr[3:0]).
- Wrap-around: pointers roll from 31 to 0 naturally; address uses the low 4 bits.
- A maximum-length packet is 1 header + up to 63 payload + 1 parity byte, which exceeds the depth. The writer is stalled by full; the FIFO never drops accepted data.

Optional Feature:
- Macro ROUTER_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow and underflow (1 bit each), both sticky.
  - overflow sets when write_enb && full.
  - underflow sets when read_enb && empty.
  - Both clear on resetn or soft_reset.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package router_pkg: MEM_WIDTH, MEM_DEPTH, ADD_WIDTH defaults; HDR_FLAG_BIT=8; localparams for the payload-length field slice [7:2] and address field slice [1:0].
- One natural sub-module, router_fifo_ptr: pointer register with increment and wrap bit, instantiated twice (write and read). Storage, flags and counter stay in router_fifo.

Test Plan:
- Reset: resetn=1 for 2 clocks -> data_out=8'h00, empty=1, full=0, and writes are ignored while resetn=1.
- Packet write/read: header 8'b000011_01 with lfd_state=1 (length 3), 3 payload bytes, 1 parity byte; then read 5 times.
  - data_out returns the 5 bytes in order, each one clock after its read edge.
  - count loads 4 on the header read and reaches 0 after the parity read.
  - data_out becomes high-Z on the next idle cycle.
- Full: 16 writes -> full=1. A 17th write with data 8'hAA is dropped; a subsequent 16-read drain returns the first 16 bytes, then empty=1.
- Simultaneous: with 8 entries stored, assert read_enb and write_enb together for 4 clocks -> occupancy stays 8, and read data stays in order across the pointer wrap.
- Soft reset mid-packet: write 10 bytes, read 3, pulse soft_reset -> empty=1, data_out=8'hZZ, count=0. The next header write/read works normally.
- Empty read: read_enb=1 with FIFO empty -> rd_ptr unchanged, empty stays 1. With ROUTER_FIFO_ERR_FLAGS_EN defined, underflow=1 until reset.
